// File: rtl/mc_cu.sv
// -----------------------------------------------------------------------------
// mc_cu -- multi-cycle control unit for the EI332 MIPS CPU with IO.
//
// Steps a shared-memory multi-cycle datapath through IF, ID, EXE, MEM and WB.
// The memory port serves instructions, data and IO. Wait states are added in
// IF and MEM until mem_ready is seen, so slow devices can stall the CPU.
//
// Ports
//   clock      in   system clock, all state changes on the rising edge
//   reset      in   synchronous, active-high
//   op, func   in   IR[31:26] / IR[5:0]
//   z          in   ALU zero flag for this cycle's ALU result
//   mem_ready  in   memory/IO finishes the current access this cycle
//   mem_req    out  memory access active
//   iord       out  address select: 0 PC, 1 ALU-out
//   wmem       out  memory write strobe
//   wir, wpc   out  load IR / load PC
//   wreg       out  register-file write
//   regrt, m2reg, shift, sext, jal  out  same meaning as the single-cycle CU
//   alusrca    out  0 PC, 1 register A (sa when shift=1)
//   alusrcb    out  00 reg B, 01 const 4, 10 ext imm, 11 sext imm<<2
//   aluc       out  ALU operation code
//   pcsource   out  00 ALU result, 01 ALU-out, 10 reg A, 11 jump address
//   state      out  current state code, for debug/IO display
//   retire     out  one-cycle pulse when an instruction completes
// -----------------------------------------------------------------------------
module mc_cu (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       wmem,
  output logic       wir,
  output logic       wpc,
  output logic       wreg,
  output logic       regrt,
  output logic       m2reg,
  output logic       shift,
  output logic       sext,
  output logic       jal,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic [2:0] state,
  output logic       retire
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [3:0] ALU_CONT = 4'b1011;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr, i_cont;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui;
  logic i_j, i_jal;
  logic legal, shift_op, imm_op, regrt_op, sext_op;
  logic [3:0] alu_code;

  assign r_type = (op == 6'h00);
  assign i_add  = r_type && (func == 6'h20);
  assign i_sub  = r_type && (func == 6'h22);
  assign i_and  = r_type && (func == 6'h24);
  assign i_or   = r_type && (func == 6'h25);
  assign i_xor  = r_type && (func == 6'h26);
  assign i_sll  = r_type && (func == 6'h00);
  assign i_srl  = r_type && (func == 6'h02);
  assign i_sra  = r_type && (func == 6'h03);
  assign i_jr   = r_type && (func == 6'h08);
  assign i_cont = r_type && (func == 6'h09);
  assign i_addi = (op == 6'h08);
  assign i_andi = (op == 6'h0c);
  assign i_ori  = (op == 6'h0d);
  assign i_xori = (op == 6'h0e);
  assign i_lui  = (op == 6'h0f);
  assign i_lw   = (op == 6'h23);
  assign i_sw   = (op == 6'h2b);
  assign i_beq  = (op == 6'h04);
  assign i_bne  = (op == 6'h05);
  assign i_j    = (op == 6'h02);
  assign i_jal  = (op == 6'h03);

  // Anything outside this set retires as a NOP from ID without any write.
  assign legal = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra |
                 i_jr | i_cont | i_addi | i_andi | i_ori | i_xori | i_lui |
                 i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

  assign shift_op = i_sll | i_srl | i_sra;
  assign imm_op   = i_addi | i_andi | i_ori | i_xori | i_lui | i_lw | i_sw;
  assign regrt_op = i_addi | i_andi | i_ori | i_xori | i_lui | i_lw;
  assign sext_op  = i_addi | i_lw | i_sw | i_beq | i_bne;

  // Branches compare with xor so that z=1 means the operands are equal.
  always_comb begin
    alu_code = ALU_ADD;
    if (i_sub)                         alu_code = ALU_SUB;
    else if (i_and | i_andi)           alu_code = ALU_AND;
    else if (i_or | i_ori)             alu_code = ALU_OR;
    else if (i_xor | i_xori | i_beq | i_bne) alu_code = ALU_XOR;
    else if (i_lui)                    alu_code = ALU_LUI;
    else if (i_sll)                    alu_code = ALU_SLL;
    else if (i_srl)                    alu_code = ALU_SRL;
    else if (i_sra)                    alu_code = ALU_SRA;
    else if (i_cont)                   alu_code = ALU_CONT;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the edge, independent of block order.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output and state_d gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    iord     = 1'b0;
    wmem     = 1'b0;
    wir      = 1'b0;
    wpc      = 1'b0;
    wreg     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    shift    = 1'b0;
    sext     = 1'b0;
    jal      = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluc     = ALU_ADD;
    pcsource = 2'b00;
    retire   = 1'b0;

    case (state_q)
      S_IF: begin
        // PC+4 is computed every IF cycle; it is only written on mem_ready.
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          wir     = 1'b1;
          wpc     = 1'b1;
          state_d = S_ID;
        end
      end

      S_ID: begin
        // The branch target goes into ALU-out now for use in EXE.
        alusrcb = 2'b11;
        if (!legal) begin
          retire  = 1'b1;
          state_d = S_IF;
        end else if (i_j | i_jal) begin
          wpc      = 1'b1;
          pcsource = 2'b11;
          wreg     = i_jal;
          jal      = i_jal;
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (i_jr) begin
          wpc      = 1'b1;
          pcsource = 2'b10;
          retire   = 1'b1;
          state_d  = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        alusrca = 1'b1;
        shift   = shift_op;
        alusrcb = imm_op ? 2'b10 : 2'b00;
        sext    = sext_op;
        aluc    = alu_code;
        if (i_beq | i_bne) begin
          wpc      = (i_beq & z) | (i_bne & ~z);
          pcsource = 2'b01;
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (i_lw | i_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        wmem    = i_sw;
        if (mem_ready) begin
          if (i_sw) begin
            retire  = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        // ALU controls repeat the EXE values so ALU-out/MDR stay valid.
        alusrca = 1'b1;
        shift   = shift_op;
        alusrcb = imm_op ? 2'b10 : 2'b00;
        sext    = sext_op;
        aluc    = alu_code;
        regrt   = regrt_op;
        m2reg   = i_lw;
        wreg    = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end

      default: begin
        // Unused codes 5-7: all strobes stay 0 and recover to IF.
        state_d = S_IF;
      end
    endcase

    // Reset aborts whatever is in flight: no write may leave this cycle.
    if (reset) begin
      mem_req = 1'b0;
      wmem    = 1'b0;
      wir     = 1'b0;
      wpc     = 1'b0;
      wreg    = 1'b0;
      retire  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// -----------------------------------------------------------------------------
// tb_mc_cu -- self-checking bench for mc_cu.
//
// A reference model turns an instruction description (class, ALU code, wait
// counts, branch flag) into the expected cycle-by-cycle output trace. Each test
// task plays such traces against the DUT and compares every cycle.
// -----------------------------------------------------------------------------
module tb_mc_cu;

  logic       clock;
  logic       reset;
  logic [5:0] op, func;
  logic       z, mem_ready;
  logic       mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg;
  logic       shift, sext, jal, alusrca, retire;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;

  mc_cu dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .wmem(wmem),
    .wir(wir), .wpc(wpc), .wreg(wreg), .regrt(regrt), .m2reg(m2reg),
    .shift(shift), .sext(sext), .jal(jal), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state),
    .retire(retire)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0100, A_AND = 4'b0001,
                         A_OR  = 4'b0101, A_XOR = 4'b0010, A_LUI = 4'b0110,
                         A_SLL = 4'b0011, A_SRL = 4'b0111, A_SRA = 4'b1111,
                         A_CONT = 4'b1011;

  typedef struct packed {
    logic [2:0] state;
    logic mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg;
    logic shift, sext, jal, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic retire;
  } outs_t;

  typedef enum {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_ILL} kind_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    kind_t      kind;
    logic [3:0] alu;
    bit         imm, sx, rt, sh;
  } info_t;

  typedef struct {
    logic  rdy;
    logic  zin;
    outs_t exp;
  } cyc_t;

  info_t isa [21];
  cyc_t  trace [$];
  int    checks = 0;
  int    errors = 0;
  logic [5:0] cur_op, cur_func;

  function automatic info_t mk(string n, logic [5:0] o, logic [5:0] f, kind_t k,
                               logic [3:0] a, bit imm, bit sx, bit rt, bit sh);
    info_t d;
    d.name = n; d.op = o; d.func = f; d.kind = k; d.alu = a;
    d.imm = imm; d.sx = sx; d.rt = rt; d.sh = sh;
    return d;
  endfunction

  task automatic init_isa();
    isa[0]  = mk("add",  6'h00, 6'h20, K_ALU, A_ADD,  0, 0, 0, 0);
    isa[1]  = mk("sub",  6'h00, 6'h22, K_ALU, A_SUB,  0, 0, 0, 0);
    isa[2]  = mk("and",  6'h00, 6'h24, K_ALU, A_AND,  0, 0, 0, 0);
    isa[3]  = mk("or",   6'h00, 6'h25, K_ALU, A_OR,   0, 0, 0, 0);
    isa[4]  = mk("xor",  6'h00, 6'h26, K_ALU, A_XOR,  0, 0, 0, 0);
    isa[5]  = mk("sll",  6'h00, 6'h00, K_ALU, A_SLL,  0, 0, 0, 1);
    isa[6]  = mk("srl",  6'h00, 6'h02, K_ALU, A_SRL,  0, 0, 0, 1);
    isa[7]  = mk("sra",  6'h00, 6'h03, K_ALU, A_SRA,  0, 0, 0, 1);
    isa[8]  = mk("cont", 6'h00, 6'h09, K_ALU, A_CONT, 0, 0, 0, 0);
    isa[9]  = mk("jr",   6'h00, 6'h08, K_JR,  A_ADD,  0, 0, 0, 0);
    isa[10] = mk("addi", 6'h08, 6'h00, K_ALU, A_ADD,  1, 1, 1, 0);
    isa[11] = mk("andi", 6'h0c, 6'h00, K_ALU, A_AND,  1, 0, 1, 0);
    isa[12] = mk("ori",  6'h0d, 6'h00, K_ALU, A_OR,   1, 0, 1, 0);
    isa[13] = mk("xori", 6'h0e, 6'h00, K_ALU, A_XOR,  1, 0, 1, 0);
    isa[14] = mk("lui",  6'h0f, 6'h00, K_ALU, A_LUI,  1, 0, 1, 0);
    isa[15] = mk("lw",   6'h23, 6'h00, K_LW,  A_ADD,  1, 1, 1, 0);
    isa[16] = mk("sw",   6'h2b, 6'h00, K_SW,  A_ADD,  1, 1, 0, 0);
    isa[17] = mk("beq",  6'h04, 6'h00, K_BEQ, A_XOR,  0, 1, 0, 0);
    isa[18] = mk("bne",  6'h05, 6'h00, K_BNE, A_XOR,  0, 1, 0, 0);
    isa[19] = mk("j",    6'h02, 6'h00, K_J,   A_ADD,  0, 0, 0, 0);
    isa[20] = mk("jal",  6'h03, 6'h00, K_JAL, A_ADD,  0, 0, 0, 0);
  endtask

  function automatic outs_t blank(logic [2:0] st);
    outs_t o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic void push(logic rdy, logic zin, outs_t o);
    cyc_t c;
    c.rdy = rdy; c.zin = zin; c.exp = o;
    trace.push_back(c);
  endfunction

  // Expected trace of one instruction from its first IF cycle to retirement.
  // Inputs that must be ignored in a cycle are randomized.
  function automatic void build(info_t d, int if_w, int mem_w, logic zv);
    outs_t o, alu;
    trace.delete();
    for (int i = 0; i < if_w; i++) begin
      o = blank(3'd0); o.mem_req = 1; o.alusrcb = 2'b01;
      push(1'b0, 1'($urandom), o);
    end
    o = blank(3'd0); o.mem_req = 1; o.alusrcb = 2'b01; o.wir = 1; o.wpc = 1;
    push(1'b1, 1'($urandom), o);

    o = blank(3'd1); o.alusrcb = 2'b11;
    case (d.kind)
      K_J:   begin o.wpc = 1; o.pcsource = 2'b11; o.retire = 1; end
      K_JAL: begin o.wpc = 1; o.pcsource = 2'b11; o.wreg = 1; o.jal = 1; o.retire = 1; end
      K_JR:  begin o.wpc = 1; o.pcsource = 2'b10; o.retire = 1; end
      K_ILL: o.retire = 1;
      default: ;
    endcase
    push(1'($urandom), 1'($urandom), o);
    if (o.retire) return;

    alu = blank(3'd2); alu.alusrca = 1; alu.alusrcb = d.imm ? 2'b10 : 2'b00;
    alu.aluc = d.alu; alu.sext = d.sx; alu.shift = d.sh;
    o = alu;
    if (d.kind == K_BEQ || d.kind == K_BNE) begin
      o.wpc = (d.kind == K_BEQ) ? zv : ~zv;
      o.pcsource = 2'b01; o.retire = 1;
      push(1'($urandom), zv, o);
      return;
    end
    push(1'($urandom), 1'($urandom), o);

    if (d.kind == K_LW || d.kind == K_SW) begin
      for (int i = 0; i <= mem_w; i++) begin
        o = blank(3'd3); o.mem_req = 1; o.iord = 1; o.wmem = (d.kind == K_SW);
        o.retire = (d.kind == K_SW) && (i == mem_w);
        push(i == mem_w, 1'($urandom), o);
      end
      if (d.kind == K_SW) return;
    end

    o = alu; o.state = 3'd4; o.wreg = 1; o.retire = 1;
    o.regrt = d.rt; o.m2reg = (d.kind == K_LW);
    push(1'($urandom), 1'($urandom), o);
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.state = state; o.mem_req = mem_req; o.iord = iord; o.wmem = wmem;
    o.wir = wir; o.wpc = wpc; o.wreg = wreg; o.regrt = regrt; o.m2reg = m2reg;
    o.shift = shift; o.sext = sext; o.jal = jal; o.alusrca = alusrca;
    o.alusrcb = alusrcb; o.aluc = aluc; o.pcsource = pcsource; o.retire = retire;
    return o;
  endfunction

  // Drives one cycle's inputs at the falling edge and samples 1 ns later.
  task automatic step(input logic rst, input logic rdy, input logic zin,
                      output outs_t obs);
    @(negedge clock);
    reset = rst; op = cur_op; func = cur_func; mem_ready = rdy; z = zin;
    #1;
    obs = sample();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    outs_t obs;
    logic [5:0] strobes;
    cur_op = 6'h00; cur_func = 6'h20;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), obs);
      strobes = {obs.wpc, obs.wir, obs.wreg, obs.wmem, obs.mem_req, obs.retire};
      checks++;
      if (strobes !== 6'b0) begin
        errors++;
        $display("FAIL reset_strobes cyc%0d: got %b want 000000", i, strobes);
      end
    end
    build(isa[0], 0, 0, 1'b0);
    foreach (trace[i]) begin
      step(1'b0, trace[i].rdy, trace[i].zin, obs);
      checks++;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("FAIL after_reset cyc%0d: got %h want %h", i, obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_latency(input int idx, input int if_w, input int mem_w,
                              input logic zv, input int want_lat);
    outs_t obs;
    int lat = 0;
    cur_op = isa[idx].op; cur_func = isa[idx].func;
    build(isa[idx], if_w, mem_w, zv);
    foreach (trace[i]) begin
      step(1'b0, trace[i].rdy, trace[i].zin, obs);
      if (obs.retire === 1'b1 && lat == 0) lat = i + 1;
      checks++;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("FAIL %s z%0d cyc%0d: got %h want %h", isa[idx].name, zv, i,
                 obs, trace[i].exp);
      end
    end
    checks++;
    if (lat != want_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", isa[idx].name, lat, want_lat);
    end
  endtask

  task automatic test_add();      test_latency(0, 0, 0, 1'b0, 4); endtask
  task automatic test_lw_wait();  test_latency(15, 0, 2, 1'b0, 7); endtask
  task automatic test_beq();
    test_latency(17, 0, 0, 1'b1, 3);
    test_latency(17, 0, 0, 1'b0, 3);
  endtask
  task automatic test_jal();      test_latency(20, 0, 0, 1'b0, 2); endtask

  task automatic test_sw_reset_abort();
    outs_t obs, exp;
    cur_op = isa[16].op; cur_func = 6'h15;
    build(isa[16], 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, trace[i].rdy, trace[i].zin, obs);
      checks++;
      if (obs !== trace[i].exp) begin
        errors++;
        $display("FAIL sw_pre cyc%0d: got %h want %h", i, obs, trace[i].exp);
      end
    end
    // First MEM cycle with reset high: no write, no retire.
    step(1'b1, 1'b1, 1'b0, obs);
    exp = blank(3'd3); exp.iord = 1;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL sw_reset_mem: got %h want %h", obs, exp);
    end
    step(1'b0, 1'b0, 1'b0, obs);
    exp = blank(3'd0); exp.mem_req = 1; exp.alusrcb = 2'b01;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL sw_reset_next: got %h want %h", obs, exp);
    end
  endtask

  // Back-to-back random instructions with random wait states.
  task automatic test_random();
    outs_t obs;
    info_t d;
    int idx, if_w, mem_w, retires = 0, n = 150;
    for (int k = 0; k < n; k++) begin
      idx = $urandom_range(0, 21);
      if (idx == 21) begin
        d = mk("illegal", 6'h00, 6'h00, K_ILL, A_ADD, 0, 0, 0, 0);
        case ($urandom_range(0, 5))
          0: d.op = 6'h01;
          1: d.op = 6'h3f;
          2: d.op = 6'h10;
          3: d.func = 6'h01;
          4: d.func = 6'h21;
          default: d.func = 6'h2a;
        endcase
      end else begin
        d = isa[idx];
      end
      cur_op = d.op;
      cur_func = (d.op == 6'h00) ? d.func : 6'($urandom);
      if_w  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      mem_w = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      build(d, if_w, mem_w, 1'($urandom));
      foreach (trace[i]) begin
        step(1'b0, trace[i].rdy, trace[i].zin, obs);
        if (obs.retire === 1'b1) retires++;
        checks++;
        if (obs !== trace[i].exp) begin
          errors++;
          $display("FAIL rand_%s #%0d cyc%0d: got %h want %h", d.name, k, i,
                   obs, trace[i].exp);
        end
      end
    end
    checks++;
    if (retires != n) begin
      errors++;
      $display("FAIL retire_count: got %0d want %0d", retires, n);
    end
  endtask

  initial begin
    reset = 1'b1; op = '0; func = '0; z = 1'b0; mem_ready = 1'b0;
    cur_op = '0; cur_func = '0;
    init_isa();
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_jal();
    test_sw_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_cu.md
# mc_cu

Multi-cycle control unit for the EI332 CPU with IO: a Moore/Mealy FSM that sequences a shared-memory multi-cycle MIPS datapath (PC, IR, register file, one ALU, ALU-out register, unified instruction/data/IO memory port) through fetch, decode, execute, memory and write-back. It supports the same instruction set and ALU encoding as the single-cycle CPU. It also inserts wait states on a memory/IO ready handshake, so slow IO devices can stall the CPU.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26]; stable from the end of IF until the next IF
- func  in  6  IR[5:0]
- z  in  1  ALU zero flag for the current cycle's ALU result
- mem_ready  in  1  memory/IO completes the current access this cycle
- mem_req  out  1  memory access active
- iord  out  1  0: address = PC; 1: address = ALU-out
- wmem  out  1  memory write strobe
- wir  out  1  load IR
- wpc  out  1  load PC
- wreg  out  1  register-file write
- regrt, m2reg, shift, sext, jal  out  1 each  same meaning as the single-cycle CU
- alusrca  out  1  0: PC; 1: register A (sa when shift=1)
- alusrcb  out  2  00 reg B, 01 const 4, 10 ext imm, 11 sext imm<<2
- aluc  out  4  ALU op: add x000, sub x100, and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111, cont 1011
- pcsource  out  2  00 ALU result, 01 ALU-out (branch target), 10 reg A (jr), 11 jump addr
- state  out  3  current state, for debug/IO display
- retire  out  1  one-cycle pulse when an instruction completes

## Operation
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Codes 5–7 are illegal and go to IF on the next edge with all strobes 0.
- Decoded instructions: add sub and or xor sll srl sra jr cont(func 09) addi andi ori xori lw sw beq bne lui j jal. Decoding of unlisted op/func is illegal: the instruction is treated as a NOP.
- IF: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - If mem_ready: wir=1, wpc=1, next ID.
  - Else: hold IF; wir=wpc=0.
- ID: alusrca=0, alusrcb=11, aluc=add, which latches the branch target into ALU-out.
  - j: wpc=1, pcsource=11, retire, next IF.
  - jal: wpc=1, pcsource=11, wreg=1, jal=1, retire, next IF. jal writes PC+4 to r31.
  - jr: wpc=1, pcsource=10, retire, next IF.
  - Illegal: retire, next IF, no writes.
  - Otherwise: next EXE.
- EXE: alusrca=1; shift for sll/srl/sra.
  - alusrcb: 10 for addi/andi/ori/xori/lui/lw/sw, else 00.
  - sext for addi/lw/sw/beq/bne.
  - aluc per the table above; beq/bne use xor.
  - beq/bne: wpc=(beq&z)|(bne&~z), pcsource=01, retire, next IF.
  - lw/sw: next MEM.
  - Others: next WB.
- MEM: mem_req=1, iord=1; wmem=1 for sw in every MEM cycle.
  - No mem_ready: hold MEM.
  - mem_ready and sw: retire, next IF.
  - mem_ready and lw: next WB.
- WB: wreg=1, retire, next IF.
  - regrt for I-type ALU ops and lw; m2reg for lw only.
- aluc, alusrc and regrt must be held stable in WB so the ALU-out/MDR path stays valid.
- Outputs not listed for a state are 0.
- mem_ready while mem_req=0 is ignored.

## Timing
- Outputs are combinational from state, op, func, z and mem_ready. State is registered.
- While reset=1: every strobe (wpc, wir, wreg, wmem, mem_req, retire) is forced to 0. State becomes IF on the edge.
- On the first cycle after reset: state=IF, mem_req=1.
- Reset mid-instruction (including MEM with sw pending): abort, no further writes; the next cycle is IF.
- Zero-wait latency, IF through retire:
  - j/jal/jr: 2 cycles
  - beq/bne: 3 cycles
  - sw: 4 cycles
  - R-type and I-type ALU ops: 4 cycles
  - lw: 5 cycles
- Each cycle with mem_ready=0 in IF or MEM adds exactly one cycle.
- retire is high in exactly one cycle per instruction.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1: strobes stay 0 during reset; then state sequence 0,1,… and wir=wpc=1 in the first IF.
- add (op 00, func 20) with mem_ready=1: states 0,1,2,4. In EXE, aluc=0000 and alusrcb=00. In WB, wreg=1, regrt=0, retire=1. Total 4 cycles.
- lw (op 23) with mem_ready low for 2 MEM cycles: MEM held 3 cycles with iord=1 and wmem=0. Then WB with m2reg=1 and regrt=1. Total 7 cycles.
- beq (op 04) run twice, z=1 then z=0: EXE wpc=1 with pcsource=01 on the first run; wpc=0 on the second. Each is 3 cycles.
- jal (op 03): ID asserts wpc=1, pcsource=11, wreg=1, jal=1, retire=1; next state IF.
- sw (op 2B) with reset asserted in the first MEM cycle: wmem=0 in that cycle, state=IF next cycle, no retire pulse.
